// File: rtl/multi_port_sync_fifo.sv
// Single-clock FIFO accepting up to WRITE_PORTS pushes and READ_PORTS pops per cycle.
// First-word-fall-through read side: the oldest READ_PORTS entries are always presented.
module multi_port_sync_fifo #(
  parameter int DEPTH       = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int WRITE_PORTS = 2,
  parameter int READ_PORTS  = 2,
  parameter int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush_i,
  input  logic [WRITE_PORTS-1:0]            push_i,
  input  logic [WRITE_PORTS*DATA_WIDTH-1:0] data_i,
  output logic                              ready_o,
  input  logic [READ_PORTS-1:0]             pop_i,
  output logic [READ_PORTS*DATA_WIDTH-1:0]  data_o,
  output logic [READ_PORTS-1:0]             valid_o,
  output logic [CNT_W-1:0]                  usage_o,
  output logic                              full_o,
  output logic                              empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_ready;
  logic [PTR_W-1:0]      w_wr_idx [WRITE_PORTS];
  int                    w_npush;
  int                    w_npop;
  logic [PTR_W-1:0]      w_rd_ptr_nxt;
  logic [PTR_W-1:0]      w_wr_ptr_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;

  // Offsets never exceed DEPTH, so a single conditional subtract suffices.
  function automatic logic [PTR_W-1:0] f_wrap(input int base, input int ofs);
    int s;
    s = base + ofs;
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  // Ready looks only at the registered count; same-cycle pops are not credited.
  assign w_ready = (int'(r_cnt) + WRITE_PORTS) <= DEPTH;

  always_comb begin
    w_npush = 0;
    for (int k = 0; k < WRITE_PORTS; k++) begin
      w_wr_idx[k] = f_wrap(int'(r_wr_ptr), w_npush);
      if (w_ready && push_i[k]) w_npush = w_npush + 1;
    end
  end

  always_comb begin
    valid_o = '0;
    w_npop  = 0;
    for (int k = 0; k < READ_PORTS; k++) begin
      valid_o[k] = int'(r_cnt) > k;
      if (pop_i[k] && valid_o[k]) w_npop = w_npop + 1;
    end
  end

  always_comb begin
    data_o = '0;
    for (int k = 0; k < READ_PORTS; k++) begin
      data_o[k*DATA_WIDTH +: DATA_WIDTH] = r_mem[f_wrap(int'(r_rd_ptr), k)];
    end
  end

  assign w_wr_ptr_nxt = f_wrap(int'(r_wr_ptr), w_npush);
  assign w_rd_ptr_nxt = f_wrap(int'(r_rd_ptr), w_npop);
  assign w_cnt_nxt    = CNT_W'(int'(r_cnt) + w_npush - w_npop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      r_rd_ptr <= w_rd_ptr_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  // Storage has no reset; a flush leaves contents in place.
  always_ff @(posedge clk) begin
    if (!flush_i) begin
      for (int k = 0; k < WRITE_PORTS; k++) begin
        if (w_ready && push_i[k]) r_mem[w_wr_idx[k]] <= data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign ready_o = w_ready;
  assign usage_o = r_cnt;
  assign full_o  = r_cnt == CNT_W'(DEPTH);
  assign empty_o = r_cnt == '0;

endmodule

// File: tb/tb_multi_port_sync_fifo.sv
// Self-checking bench for multi_port_sync_fifo (DEPTH=6, 2 write / 2 read lanes).
// A queue-based reference model predicts every output after each clock edge.
module tb_multi_port_sync_fifo;

  localparam int DEPTH = 6;
  localparam int DW    = 32;
  localparam int WP    = 2;
  localparam int RP    = 2;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst_n;
  logic              flush_i;
  logic [WP-1:0]     push_i;
  logic [WP*DW-1:0]  data_i;
  logic              ready_o;
  logic [RP-1:0]     pop_i;
  logic [RP*DW-1:0]  data_o;
  logic [RP-1:0]     valid_o;
  logic [CNT_W-1:0]  usage_o;
  logic              full_o;
  logic              empty_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] model_q [$];

  multi_port_sync_fifo #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW), .WRITE_PORTS(WP), .READ_PORTS(RP)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .push_i(push_i), .data_i(data_i), .ready_o(ready_o),
    .pop_i(pop_i), .data_o(data_o), .valid_o(valid_o),
    .usage_o(usage_o), .full_o(full_o), .empty_o(empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int sz;
    logic [RP-1:0] exp_valid;
    sz = model_q.size();
    exp_valid = '0;
    for (int k = 0; k < RP; k++) exp_valid[k] = (sz > k);
    chk("usage", 64'(usage_o), 64'(sz));
    chk("valid", 64'(valid_o), 64'(exp_valid));
    chk("ready", 64'(ready_o), 64'((DEPTH - sz) >= WP));
    chk("full",  64'(full_o),  64'(sz == DEPTH));
    chk("empty", 64'(empty_o), 64'(sz == 0));
    for (int k = 0; k < RP; k++)
      if (k < sz) chk($sformatf("data_lane%0d", k), 64'(data_o[k*DW +: DW]), 64'(model_q[k]));
  endtask

  // Apply one cycle of stimulus, advance the model across the edge, then check.
  task automatic step(input logic fl, input logic [WP-1:0] pu, input logic [DW-1:0] d0,
                      input logic [DW-1:0] d1, input logic [RP-1:0] po);
    int sz0;
    int npop;
    bit rdy;
    flush_i = fl;
    push_i  = pu;
    data_i  = {d1, d0};
    pop_i   = po;
    @(posedge clk);
    sz0 = model_q.size();
    rdy = (DEPTH - sz0) >= WP;
    if (fl) begin
      model_q.delete();
    end else begin
      npop = 0;
      for (int k = 0; k < RP; k++) if (po[k] && sz0 > k) npop++;
      repeat (npop) void'(model_q.pop_front());
      if (rdy) begin
        if (pu[0]) model_q.push_back(d0);
        if (pu[1]) model_q.push_back(d1);
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    flush_i = 1'b0;
    push_i  = '0;
    data_i  = '0;
    pop_i   = '0;
  endtask

  initial begin
    logic [RP-1:0] po;
    int nxt;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs();

    // Both lanes pushed in one cycle.
    step(1'b0, 2'b11, 32'hAAAA_0001, 32'hBBBB_0002, 2'b00);
    chk("t1_lane0", 64'(data_o[0 +: DW]), 64'h0000_0000_AAAA_0001);
    step(1'b0, 2'b00, 0, 0, 2'b11);

    // Sparse push on lane1 only compacts to a single entry.
    step(1'b0, 2'b10, 32'h0, 32'hB0B0_B0B0, 2'b00);
    chk("t2_valid", 64'(valid_o), 64'b01);
    step(1'b0, 2'b00, 0, 0, 2'b01);

    // Fill to 5, then an ignored push, then a single pop.
    step(1'b0, 2'b11, 32'h10, 32'h11, 2'b00);
    step(1'b0, 2'b11, 32'h12, 32'h13, 2'b00);
    step(1'b0, 2'b01, 32'h14, 32'h0,  2'b00);
    chk("t3_ready_at5", 64'(ready_o), 64'd0);
    step(1'b0, 2'b11, 32'hDEAD, 32'hBEEF, 2'b00);
    chk("t3_usage_ignored", 64'(usage_o), 64'd5);
    step(1'b0, 2'b00, 0, 0, 2'b01);
    chk("t3_ready_after_pop", 64'(ready_o), 64'd1);
    step(1'b1, 2'b00, 0, 0, 2'b00);

    // Stream 0..19 through, two per cycle each way, forcing pointer wrap.
    nxt = 0;
    for (int c = 0; c < 12; c++) begin
      if (nxt < 20) begin
        step(1'b0, 2'b11, 32'(nxt), 32'(nxt + 1), 2'b11);
        nxt += 2;
      end else begin
        step(1'b0, 2'b00, 0, 0, 2'b11);
      end
    end
    chk("t4_drained", 64'(empty_o), 64'd1);

    // One entry, pop both lanes and push both lanes together.
    step(1'b0, 2'b01, 32'h500, 32'h0, 2'b00);
    step(1'b0, 2'b11, 32'h501, 32'h502, 2'b11);
    chk("t5_usage", 64'(usage_o), 64'd2);
    chk("t5_oldest", 64'(data_o[0 +: DW]), 64'h501);

    // Flush wins over simultaneous push and pop at usage 3.
    step(1'b0, 2'b01, 32'h600, 32'h0, 2'b00);
    chk("t6_pre_usage", 64'(usage_o), 64'd3);
    step(1'b1, 2'b11, 32'h601, 32'h602, 2'b11);
    chk("t6_valid", 64'(valid_o), 64'd0);

    // Randomised traffic with occasional flushes and async resets.
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(2, 0))
        0: po = 2'b00;
        1: po = 2'b01;
        default: po = 2'b11;
      endcase
      step(($urandom_range(31, 0) == 0), 2'($urandom), $urandom, $urandom, po);
      if ($urandom_range(79, 0) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        check_outputs();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outputs();
      end
    end

    // Deterministic mid-stream async reset.
    step(1'b0, 2'b11, 32'h700, 32'h701, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    model_q.delete();
    check_outputs();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
